port_tx_gmii: RTL and testbench
===============================

# port_tx_gmii

Transmit MAC stage that consumes the byte stream produced by the distributor (`p_srdy`/`p_drdy`/`p_code`/`p_data`) and drives a GMII transmit interface. It frames each packet on the wire:
- inserts preamble and SFD;
- flags underruns and bad packets with `gmii_tx_er`;
- optionally appends the 802.3 FCS;
- enforces a minimum inter-frame gap.

## Interface
- `ifg`, default 12: idle cycles enforced after each frame; legal range 1–255.
- `clk`  input  1  single clock for all logic.
- `reset`  input  1  asynchronous, active-low reset.
- `p_srdy`  input  1  upstream byte valid.
- `p_drdy`  output  1  byte accepted this cycle when `p_srdy & p_drdy`.
- `p_code`  input  2  byte code: 00 DATA, 01 SOP, 10 EOP, 11 BADEOP.
- `p_data`  input  8  byte payload.
- `gmii_tx_en`  output  1  registered transmit enable.
- `gmii_tx_er`  output  1  registered transmit error.
- `gmii_txd`  output  8  registered transmit data.

## Operation
- States: IDLE, PRE, SFD, DATA, FCS, ABORT, IFG.
- Reset asserted:
  - state IDLE;
  - `gmii_tx_en`=0, `gmii_tx_er`=0, `gmii_txd`=0;
  - counters 0;
  - `p_drdy`=0.
- `p_drdy` is combinational from state and inputs:
  - IDLE: 1 only when `p_srdy` and `p_code`!=SOP. Stray non-SOP bytes are discarded with no GMII activity.
  - SFD, DATA, ABORT: 1.
  - All other states: 0.
- IDLE with `p_srdy` and `p_code`=SOP: go to PRE. The SOP byte is not consumed.
- PRE: drives 0x55 with tx_en=1 for 7 cycles, then SFD.
- SFD:
  - drives 0xD5 with tx_en=1;
  - accepts the SOP byte;
  - moves to DATA.
- DATA and SFD, byte accepted: `gmii_txd`<=`p_data`, tx_en<=1 on the next edge.
- Codes within a frame:
  - SOP after the first byte is treated as DATA.
  - EOP: byte transmitted normally; next state is FCS when the FCS feature is enabled, else IFG.
  - BADEOP: byte transmitted with tx_er=1; FCS is never appended; next state IFG.
- Underrun: in SFD or DATA with `p_srdy`=0:
  - next GMII cycle has tx_en=1, tx_er=1, txd=0;
  - then state ABORT.
- ABORT:
  - GMII idle (tx_en=0, tx_er=0, txd=0);
  - bytes consumed and discarded until an EOP or BADEOP byte is accepted;
  - then IFG.
- IFG:
  - GMII idle for exactly `ifg` cycles;
  - counter loads `ifg` on entry and counts down;
  - then IDLE.
- GMII idle encoding everywhere outside frames: tx_en=0, tx_er=0, txd=0x00.

## Timing
- SOP seen in IDLE at cycle 0:
  - 0x55 on cycles 1–7;
  - 0xD5 on cycle 8;
  - SOP byte accepted cycle 8, on GMII cycle 9.
- Byte accepted in cycle N appears on GMII in cycle N+1.
- Last tx_en=1 cycle (last byte, FCS byte, or underrun error cycle) is followed by `ifg` idle cycles, then one IDLE decision cycle.
- Minimum tx_en-low gap between frames is therefore `ifg`+1.
- ABORT adds its own idle cycles before IFG.
- Reset is asynchronous and may assert mid-frame: outputs go to reset values immediately, with no error signalling. The upstream partial packet is the producer's responsibility.

## Configuration
- Macro: `PORT_TX_FCS_EN`.
- Defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement) runs over all bytes accepted in SFD/DATA;
  - after EOP, state FCS drives 4 bytes, least-significant byte first, with tx_en=1;
  - CRC reinitialised on entry to PRE.
- Undefined:
  - no CRC logic and no FCS state;
  - EOP goes directly to IFG.

## Test plan
- Basic frame, FCS off, ifg=12: SOP 0x01, DATA 0x02, DATA 0x03, EOP 0x04 held valid.
  - Required: GMII 0x55×7, 0xD5, 0x01..0x04, tx_en low exactly 13 cycles before next frame's first 0x55.
- FCS on: frame of ASCII bytes 0x31..0x39 (SOP first, EOP last).
  - Required: after 0x39, FCS bytes 0x26, 0x39, 0xF4, 0xCB, then tx_en=0.
- Underrun: `p_srdy` dropped for one cycle after the second data byte of a 6-byte frame.
  - Required: one cycle tx_en=1/tx_er=1/txd=0, then idle.
  - Remaining bytes consumed through EOP with no GMII activity, then 12 IFG cycles.
- BADEOP: 3-byte frame ending in BADEOP 0xAA.
  - Required: 0xAA transmitted with tx_er=1; no FCS even with `PORT_TX_FCS_EN`.
- Stray bytes: DATA 0x11 and EOP 0x22 presented in IDLE.
  - Required: both consumed (`p_drdy`=1), GMII stays idle.
  - A following SOP frame transmits normally.
- Reset mid-frame: `reset` low during byte 3 of DATA.
  - Required: tx_en, tx_er and txd go to 0 asynchronously; `p_drdy`=0.
  - After release the block is in IDLE and the next SOP yields a full preamble.

Source files
------------

// File: rtl/port_tx_gmii.sv
// GMII transmit MAC stage: frames the distributor byte stream with preamble/SFD,
// error marking and inter-frame gap. Define PORT_TX_FCS_EN to append the CRC-32 FCS.
module port_tx_gmii #(
  parameter int unsigned ifg = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_srdy,
  output logic       p_drdy,
  input  logic [1:0] p_code,
  input  logic [7:0] p_data,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] gmii_txd
);

  localparam logic [1:0] C_SOP = 2'b01, C_EOP = 2'b10, C_BAD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_SFD   = 3'd2,
    S_DATA  = 3'd3,
    S_ABORT = 3'd4,
    S_IFG   = 3'd5
`ifdef PORT_TX_FCS_EN
    , S_FCS = 3'd6
`endif
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_tx_en, r_tx_er;
  logic [7:0] r_txd;
  logic       w_drdy;

`ifdef PORT_TX_FCS_EN
  logic [31:0] r_crc;
  logic [31:0] w_fcs;

  // Reflected CRC-32 (poly 0x04C11DB7 bit-reversed), one byte per call.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  assign w_fcs = ~r_crc;
`endif

  always_comb begin
    w_drdy = 1'b0;
    case (r_state)
      S_IDLE:                 w_drdy = p_srdy && (p_code != C_SOP);
      S_SFD, S_DATA, S_ABORT: w_drdy = 1'b1;
      default:                w_drdy = 1'b0;
    endcase
  end

  // Gate with reset so nothing is accepted while the block is held in reset.
  assign p_drdy     = w_drdy & reset;
  assign gmii_tx_en = r_tx_en;
  assign gmii_tx_er = r_tx_er;
  assign gmii_txd   = r_txd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_tx_en <= 1'b0;
      r_tx_er <= 1'b0;
      r_txd   <= 8'd0;
`ifdef PORT_TX_FCS_EN
      r_crc   <= 32'hFFFFFFFF;
`endif
    end else begin
      r_tx_en <= 1'b0;
      r_tx_er <= 1'b0;
      r_txd   <= 8'd0;
      case (r_state)
        S_IDLE: if (p_srdy && p_code == C_SOP) begin
          r_state <= S_PRE;
          r_tx_en <= 1'b1;
          r_txd   <= 8'h55;
          r_cnt   <= 8'd0;
`ifdef PORT_TX_FCS_EN
          r_crc   <= 32'hFFFFFFFF;
`endif
        end
        S_PRE: begin
          r_tx_en <= 1'b1;
          if (r_cnt == 8'd6) begin
            r_txd   <= 8'hD5;
            r_state <= S_SFD;
          end else begin
            r_txd <= 8'h55;
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_SFD, S_DATA: if (p_srdy) begin
          r_tx_en <= 1'b1;
          r_txd   <= p_data;
          r_state <= S_DATA;
`ifdef PORT_TX_FCS_EN
          r_crc   <= crc_byte(r_crc, p_data);
`endif
          case (p_code)
            C_EOP: begin
`ifdef PORT_TX_FCS_EN
              r_state <= S_FCS;
              r_cnt   <= 8'd0;
`else
              r_state <= S_IFG;
              r_cnt   <= 8'(ifg);
`endif
            end
            C_BAD: begin
              r_tx_er <= 1'b1;
              r_state <= S_IFG;
              r_cnt   <= 8'(ifg);
            end
            default: ;
          endcase
        end else begin
          // Underrun: one error cycle on the wire, then drain the packet silently.
          r_tx_en <= 1'b1;
          r_tx_er <= 1'b1;
          r_state <= S_ABORT;
        end
        S_ABORT: if (p_srdy && (p_code == C_EOP || p_code == C_BAD)) begin
          r_state <= S_IFG;
          r_cnt   <= 8'(ifg);
        end
        S_IFG: begin
          if (r_cnt == 8'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 8'd1;
        end
`ifdef PORT_TX_FCS_EN
        S_FCS: begin
          r_tx_en <= 1'b1;
          r_txd   <= w_fcs[{r_cnt[1:0], 3'b000} +: 8];
          if (r_cnt == 8'd3) begin
            r_state <= S_IFG;
            r_cnt   <= 8'(ifg);
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_tx_gmii.sv
// Bench for port_tx_gmii: table of framed bytes feeding a scoreboard of expected
// GMII bytes, plus hand sequences for underrun, stray bytes and mid-frame reset.
module tb_port_tx_gmii;

  localparam logic [1:0] C_DATA = 2'b00, C_SOP = 2'b01, C_EOP = 2'b10, C_BAD = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p_srdy = 1'b0;
  logic       p_drdy;
  logic [1:0] p_code = 2'b00;
  logic [7:0] p_data = 8'h00;
  logic       gmii_tx_en, gmii_tx_er;
  logic [7:0] gmii_txd;

  always #5 clk = ~clk;

  port_tx_gmii #(.ifg(12)) dut (
    .clk(clk), .reset(reset), .p_srdy(p_srdy), .p_drdy(p_drdy),
    .p_code(p_code), .p_data(p_data),
    .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .gmii_txd(gmii_txd)
  );

  typedef struct packed { logic chk; logic er; logic [7:0] txd; } exp_t;
  typedef struct {
    logic [1:0]  code;
    logic [7:0]  data;
    logic        exp_er;
    logic [7:0]  exp_txd;
    logic [31:0] fcs;
    logic        fcs_chk;
  } vec_t;

  exp_t q[$];
  int   gaps[$];
  int   errors = 0, checks = 0;
  int   low = 0;
  bit   had = 0, prev_en = 0, in_frame = 0, drdy_s = 0;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard side: every tx_en cycle must match the next queued byte.
  task automatic sample();
    exp_t e;
    drdy_s = p_drdy;
    if (gmii_tx_en === 1'b1) begin
      if (!prev_en && had) gaps.push_back(low);
      low = 0;
      had = 1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: got txd=%h er=%b expected no transmission at %0t",
                 gmii_txd, gmii_tx_er, $time);
      end else begin
        e = q.pop_front();
        if (e.chk) chk("gmii_byte", 32'({gmii_tx_er, gmii_txd}), 32'({e.er, e.txd}));
      end
    end else begin
      low++;
      chk("idle_enc", 32'({gmii_tx_er, gmii_txd}), 32'h0);
    end
    prev_en = gmii_tx_en;
  endtask

  task automatic cyc();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d);
    bit ok;
    ok = 0;
    p_srdy = 1'b1;
    p_code = c;
    p_data = d;
    for (int t = 0; t < 200; t++) begin
      cyc();
      if (drdy_s) begin
        ok = 1;
        break;
      end
    end
    p_srdy = 1'b0;
    chk("byte_accepted", 32'(ok), 32'd1);
  endtask

  task automatic send_row(input vec_t v);
    if (v.code == C_SOP && !in_frame) begin
      for (int k = 0; k < 7; k++) q.push_back({1'b1, 1'b0, 8'h55});
      q.push_back({1'b1, 1'b0, 8'hD5});
      in_frame = 1;
    end
    q.push_back({1'b1, v.exp_er, v.exp_txd});
    if (v.code == C_EOP) begin
`ifdef PORT_TX_FCS_EN
      for (int k = 0; k < 4; k++) q.push_back({v.fcs_chk, 1'b0, v.fcs[8*k +: 8]});
`endif
      in_frame = 0;
    end
    if (v.code == C_BAD) in_frame = 0;
    send(v.code, v.data);
  endtask

  task automatic row(input logic [1:0] c, input logic [7:0] d);
    vec_t v;
    v = '{c, d, (c == C_BAD), d, 32'h0, 1'b0};
    send_row(v);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] c;
    tbl[0] = '{C_SOP,  8'h01, 1'b0, 8'h01, 32'h0, 1'b0};
    tbl[1] = '{C_DATA, 8'h02, 1'b0, 8'h02, 32'h0, 1'b0};
    tbl[2] = '{C_DATA, 8'h03, 1'b0, 8'h03, 32'h0, 1'b0};
    tbl[3] = '{C_EOP,  8'h04, 1'b0, 8'h04, 32'h0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      c = (i == 0) ? C_SOP : (i == 8) ? C_EOP : C_DATA;
      tbl[4+i] = '{c, 8'(8'h31 + i), 1'b0, 8'(8'h31 + i), 32'hCBF43926, 1'b1};
    end
    tbl[13] = '{C_SOP, 8'h10, 1'b0, 8'h10, 32'h0, 1'b0};
    tbl[14] = '{C_SOP, 8'h20, 1'b0, 8'h20, 32'h0, 1'b0};
    tbl[15] = '{C_BAD, 8'hAA, 1'b1, 8'hAA, 32'h0, 1'b0};

    // Reset state, with a valid DATA byte offered that must not be accepted.
    p_srdy = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("rst_tx_en", 32'(gmii_tx_en), 32'd0);
    chk("rst_tx_er", 32'(gmii_tx_er), 32'd0);
    chk("rst_txd",   32'(gmii_txd),   32'd0);
    chk("rst_drdy",  32'(p_drdy),     32'd0);
    cyc();
    cyc();
    p_srdy = 1'b0;
    reset  = 1'b1;
    repeat (3) cyc();

    // Basic frame, ASCII FCS frame, BADEOP frame, back to back.
    for (int i = 0; i < 16; i++) send_row(tbl[i]);

    // Underrun after the second data byte of a 6-byte frame.
    row(C_SOP, 8'h60);
    row(C_DATA, 8'h61);
    row(C_DATA, 8'h62);
    p_srdy = 1'b0;
    q.push_back({1'b1, 1'b1, 8'h00});
    cyc();
    send(C_DATA, 8'h63);
    send(C_DATA, 8'h64);
    send(C_EOP, 8'h65);
    in_frame = 0;
    row(C_SOP, 8'h70);
    row(C_EOP, 8'h71);
    repeat (40) cyc();

    chk("gap_basic",    32'((gaps.size() > 0) ? gaps[0] : -1), 32'd13);
    chk("gap_fcs",      32'((gaps.size() > 1) ? gaps[1] : -1), 32'd13);
    chk("gap_badeop",   32'((gaps.size() > 2) ? gaps[2] : -1), 32'd13);
    chk("gap_underrun", 32'((gaps.size() > 3) ? gaps[3] : -1), 32'd16);

    // Stray non-SOP bytes in IDLE are consumed with no GMII activity.
    p_srdy = 1'b1;
    p_code = C_DATA;
    p_data = 8'h11;
    cyc();
    chk("stray_data_drdy", 32'(drdy_s), 32'd1);
    p_code = C_EOP;
    p_data = 8'h22;
    cyc();
    chk("stray_eop_drdy", 32'(drdy_s), 32'd1);
    p_srdy = 1'b0;
    repeat (3) cyc();
    row(C_SOP, 8'h41);
    row(C_DATA, 8'h42);
    row(C_EOP, 8'h43);
    repeat (40) cyc();

    // Asynchronous reset while the third data byte is offered.
    row(C_SOP, 8'h50);
    row(C_DATA, 8'h51);
    row(C_DATA, 8'h52);
    p_srdy = 1'b1;
    p_code = C_DATA;
    p_data = 8'h53;
    #2 reset = 1'b0;
    #1;
    chk("midrst_tx_en", 32'(gmii_tx_en), 32'd0);
    chk("midrst_tx_er", 32'(gmii_tx_er), 32'd0);
    chk("midrst_txd",   32'(gmii_txd),   32'd0);
    chk("midrst_drdy",  32'(p_drdy),     32'd0);
    q.delete();
    in_frame = 0;
    cyc();
    chk("midrst_drdy_held", 32'(drdy_s), 32'd0);
    cyc();
    p_srdy = 1'b0;
    #2 reset = 1'b1;
    cyc();
    row(C_SOP, 8'h80);
    row(C_DATA, 8'h81);
    row(C_EOP, 8'h82);
    repeat (40) cyc();

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
